fir_coeff_mac: RTL and testbench
================================

Name: fir_coeff_mac

Overview:
- Reader-side companion to the double-banked coefficient store: a time-multiplexed FIR MAC engine for the WM8731 audio path.
- Accepts one audio sample per handshake and holds a TAPS-deep sample history.
- Streams coefficients out of the coefficient store's read port (rd_addr/rd_data) and emits one filtered sample per input.
- Defers coefficient bank swaps (coeff_up) to sample boundaries, so a swap never lands mid-convolution.

Parameters:
- TAPS, 256, number of taps; must be ≤ 256, which is the coefficient bank depth.
- OUT_SHIFT, 15, arithmetic right shift applied to the accumulator (Q15 coefficients).
- ACC_W, 40, accumulator width; signed.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_data  in  16  signed input sample
- in_valid  in  1  input sample valid
- in_ready  out  1  engine can accept a sample
- out_data  out  16  signed saturated filter output
- out_valid  out  1  one-cycle pulse; out_data is valid while high
- coef_rd_addr  out  9  coefficient read address to the store
- coef_rd_data  in  16  signed coefficient; valid 1 cycle after the address is driven
- coef_wr_en  in  1  monitor of the store's wr_en; when high, the read port is hijacked by the writer
- swap_req  in  1  pulse from the coefficient loader: new bank is complete
- coeff_up  out  1  one-cycle pulse to the store that toggles the active bank
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, coeff_up=0, coef_rd_addr=0, busy=1; swap pending flag cleared; state=CLEAR.
- CLEAR:
  - Writes 0 to history entries 0..TAPS-1, one entry per cycle.
  - Then wr_ptr=0 and the state goes to IDLE.
  - Duration is exactly TAPS cycles after reset deasserts.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: write in_data to hist[wr_ptr], newest=wr_ptr, wr_ptr=(wr_ptr+1) mod TAPS, acc=0, k=0, then go to RUN.
- RUN:
  - Each cycle drive coef_rd_addr=k and the history read address (newest−k) mod TAPS.
  - The issue counts only if coef_wr_en=0 that cycle; only then does k increment.
  - If coef_wr_en=1, the same k is re-issued the next cycle.
  - An issued-valid flag follows the read by 1 cycle. When set, acc += sext(coef_rd_data*hist_q); the product is a 32-bit signed value.
  - After k=TAPS−1 issues validly, go to DRAIN.
- DRAIN: one cycle, which absorbs the final accumulate; then go to OUT.
- OUT:
  - out_data = sat16(acc >>> OUT_SHIFT), clamped to [−32768, 32767].
  - out_valid=1 for this single cycle; then go to IDLE.
  - out_data holds its value until the next OUT.
- Latency: with the accept at edge E, out_valid is high in the cycle after edge E+TAPS+2. Each coef_wr_en stall cycle during RUN adds 1 cycle.
- History wrap: indices are mod TAPS. A sample accepted at wr_ptr=TAPS−1 wraps to 0.
- Swap deferral:
  - pend_next = swap_req | (pend & ~coeff_up).
  - coeff_up = pend & (state==IDLE), combinational.
  - Multiple swap_req pulses while busy merge into one coeff_up.
  - A swap_req in the coeff_up cycle re-arms pend.
  - coeff_up and a sample accept in the same IDLE cycle are legal. The first RUN read then hits the new bank.
- Reset mid-RUN: the result is discarded, the state goes to CLEAR and pend is cleared. coeff_up must not fire until IDLE is reached again.
- in_valid outside IDLE is ignored; the sample is held by the upstream.

Decomposition:
- Shared package, fir_pkg:
  - COEF_ADDR_W=9, SAMPLE_W=16, COEF_W=16.
  - State encoding {CLEAR, IDLE, RUN, DRAIN, OUT}.
  - sat16 rule.
- Sub-module fir_sample_hist: TAPS×16 single-port RAM with synchronous read, 1-cycle latency matching the coefficient store. Writes (CLEAR, accept) and reads (RUN) never overlap.

Test Plan:
- Reset, then idle → in_ready=0 for exactly 256 cycles, then 1; coeff_up and out_valid stay 0 throughout.
- Impulse response: h[0]=0x4000, all others 0; accept 1000 → out_data=500, out_valid exactly 258 cycles after the accept edge.
- Tap delay: h[3]=0x7FFF, others 0; feed 1000, 0, 0, 0 → outputs 0, 0, 0, 999.
- Saturation: all h=0x7FFF; feed 256× +32767 → last out_data=32767. Feed 256× −32768 → last out_data=−32768.
- Read-port stall: pulse coef_wr_en high for 5 cycles mid-RUN with the impulse setup → out_data=500, out_valid at 263 cycles.
- Swap deferral: two swap_req pulses during RUN → coeff_up=0 while busy, then exactly one 1-cycle pulse in the first IDLE cycle. The next sample uses the new bank.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, engine state encoding and output saturation for the FIR MAC.
package fir_pkg;
  localparam int COEF_ADDR_W = 9;
  localparam int SAMPLE_W = 16;
  localparam int COEF_W = 16;
  typedef enum logic [2:0] {CLEAR, IDLE, RUN, DRAIN, OUT} state_t;
  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [63:0] x);
    return x > 64'sd32767 ? 16'sh7FFF : x < -64'sd32768 ? 16'sh8000 : x[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/fir_sample_hist.sv
// fir_sample_hist: TAPS-deep sample history RAM, single port, synchronous read with 1-cycle latency.
// Ports: clk; we/addr/wdata write port; rdata is mem[addr] registered on the same edge.
module fir_sample_hist import fir_pkg::*; #(
  parameter int TAPS = 256,
  parameter int AW = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [AW-1:0]              addr,
  input  logic signed [SAMPLE_W-1:0] wdata,
  output logic signed [SAMPLE_W-1:0] rdata
);
  logic signed [SAMPLE_W-1:0] mem [TAPS];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/fir_coeff_mac.sv
// fir_coeff_mac: time-multiplexed FIR MAC reading coefficients from a double-banked store, with bank swaps deferred to sample boundaries.
// Ports: clk/rst (sync, active-high); in_data/in_valid/in_ready sample input; out_data/out_valid
// filtered output pulse; coef_rd_addr/coef_rd_data store read port (1-cycle latency); coef_wr_en
// marks read-port hijack by the writer; swap_req requests a bank swap, coeff_up performs it; busy = not IDLE.
module fir_coeff_mac import fir_pkg::*; #(
  parameter int TAPS = 256,
  parameter int OUT_SHIFT = 15,
  parameter int ACC_W = 40
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [SAMPLE_W-1:0]    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic signed [SAMPLE_W-1:0]    out_data,
  output logic                          out_valid,
  output logic [COEF_ADDR_W-1:0]        coef_rd_addr,
  input  logic signed [COEF_W-1:0]      coef_rd_data,
  input  logic                          coef_wr_en,
  input  logic                          swap_req,
  output logic                          coeff_up,
  output logic                          busy
);
  localparam int HW = TAPS > 1 ? $clog2(TAPS) : 1;
  localparam logic [HW-1:0] LAST = HW'(TAPS - 1);
  state_t state;
  logic [HW-1:0] wr_ptr, next_wr, newest, rd_ptr, h_addr;
  logic [COEF_ADDR_W-1:0] k;
  logic signed [ACC_W-1:0] acc;
  logic signed [SAMPLE_W-1:0] hist_q, h_wdata;
  logic signed [2*SAMPLE_W-1:0] prod;
  logic vld, pend, accept, h_we;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign accept = in_ready && in_valid;
  assign coeff_up = pend && state == IDLE;
  assign coef_rd_addr = k;
  assign next_wr = wr_ptr == LAST ? '0 : wr_ptr + HW'(1);
  // (newest - k) mod TAPS; the wrap branch stays exact even when TAPS fills the pointer width
  assign rd_ptr = newest >= k[HW-1:0] ? newest - k[HW-1:0] : newest - k[HW-1:0] + LAST + HW'(1);
  assign h_addr = state == RUN ? rd_ptr : wr_ptr;
  assign h_we = state == CLEAR || accept;
  assign h_wdata = accept ? in_data : '0;
  assign prod = 32'(coef_rd_data) * 32'(hist_q);
  fir_sample_hist #(.TAPS(TAPS), .AW(HW)) u_hist (
    .clk(clk), .we(h_we), .addr(h_addr), .wdata(h_wdata), .rdata(hist_q)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      wr_ptr <= '0;
      newest <= '0;
      k <= '0;
      acc <= '0;
      vld <= 1'b0;
      pend <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      pend <= swap_req | (pend & ~coeff_up);
      vld <= state == RUN && !coef_wr_en;
      out_valid <= state == OUT;
      if (vld) acc <= acc + ACC_W'(prod);
      case (state)
        CLEAR: begin
          wr_ptr <= next_wr;
          if (wr_ptr == LAST) state <= IDLE;
        end
        IDLE: if (in_valid) begin
          newest <= wr_ptr;
          wr_ptr <= next_wr;
          acc <= '0;
          k <= '0;
          state <= RUN;
        end
        RUN: if (!coef_wr_en) begin
          if (k == COEF_ADDR_W'(TAPS - 1)) state <= DRAIN;
          else k <= k + COEF_ADDR_W'(1);
        end
        DRAIN: state <= OUT;
        OUT: begin
          out_data <= sat16(64'(acc >>> OUT_SHIFT));
          state <= IDLE;
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_coeff_mac.sv
// tb_fir_coeff_mac: directed checks of clear, impulse, tap delay, saturation, read stall, swap deferral and mid-run reset.
module tb_fir_coeff_mac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready, out_valid, coeff_up, busy;
  logic signed [15:0] out_data;
  logic [8:0] coef_rd_addr;
  logic signed [15:0] coef_rd_data;
  logic coef_wr_en = 1'b0;
  logic swap_req = 1'b0;
  logic signed [15:0] bank [2][256];
  bit act = 1'b0;
  int checks = 0;
  int errors = 0;

  fir_coeff_mac dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .coef_rd_addr(coef_rd_addr),
    .coef_rd_data(coef_rd_data), .coef_wr_en(coef_wr_en), .swap_req(swap_req),
    .coeff_up(coeff_up), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (coeff_up) act <= ~act;
    coef_rd_data <= coef_wr_en ? 16'sh7FFF : bank[act][coef_rd_addr[7:0]];
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input bit b, input logic signed [15:0] v);
    for (int i = 0; i < 256; i++) bank[b][i] = v;
  endtask

  task automatic do_reset();
    int n, hi;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_coeff_up", coeff_up, 0);
    check("rst_rd_addr", coef_rd_addr, 0);
    rst = 1'b0;
    n = 0;
    hi = 0;
    while (!in_ready && n < 1000) begin
      n++;
      hi += int'(coeff_up) + int'(out_valid);
      @(negedge clk);
    end
    check("clear_len", n, 256);
    check("clear_quiet", hi, 0);
  endtask

  task automatic accept(input logic signed [15:0] s);
    check("accept_ready", in_ready, 1);
    in_data = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(input int stall_at, input int swap_at, output logic signed [15:0] d,
                          output int lat, output int cu_busy, output logic cu_out);
    lat = 0;
    cu_busy = 0;
    cu_out = 1'bx;
    d = 'x;
    for (int m = 0; m < 600; m++) begin
      @(negedge clk);
      if (stall_at > 0) coef_wr_en = m >= stall_at && m < stall_at + 5;
      if (swap_at > 0) swap_req = m == swap_at || m == swap_at + 20;
      if (out_valid) begin
        lat = m;
        d = out_data;
        cu_out = coeff_up;
        break;
      end
      cu_busy += int'(coeff_up);
    end
    coef_wr_en = 1'b0;
    swap_req = 1'b0;
  endtask

  initial begin
    logic signed [15:0] d;
    int lat, cub;
    logic cuo;
    logic signed [15:0] tap_in [4] = '{16'sd1000, 16'sd0, 16'sd0, 16'sd0};
    logic signed [15:0] tap_exp [4] = '{16'sd0, 16'sd0, 16'sd0, 16'sd999};
    logic signed [15:0] sat_in [5] = '{16'sd32767, 16'sd32767, -16'sd32768, -16'sd32768, -16'sd32768};
    logic signed [15:0] sat_exp [5] = '{16'sd32766, 16'sd32767, 16'sd32765, -16'sd2, -16'sd32768};
    fill(0, 16'sd0);
    fill(1, 16'sd0);
    do_reset();

    bank[act][0] = 16'sh4000;
    accept(16'sd1000);
    wait_out(0, 0, d, lat, cub, cuo);
    check("impulse_out", d, 500);
    check("impulse_lat", lat, 258);
    check("impulse_cu", cub, 0);
    @(negedge clk);
    check("pulse_width", out_valid, 0);
    check("out_hold", out_data, 500);

    do_reset();
    fill(act, 16'sd0);
    bank[act][3] = 16'sh7FFF;
    for (int i = 0; i < 4; i++) begin
      accept(tap_in[i]);
      wait_out(0, 0, d, lat, cub, cuo);
      check($sformatf("tap_out%0d", i), d, tap_exp[i]);
    end

    do_reset();
    fill(act, 16'sh7FFF);
    for (int i = 0; i < 5; i++) begin
      accept(sat_in[i]);
      wait_out(0, 0, d, lat, cub, cuo);
      check($sformatf("sat_out%0d", i), d, sat_exp[i]);
    end

    do_reset();
    fill(act, 16'sd0);
    bank[act][0] = 16'sh4000;
    accept(16'sd1000);
    wait_out(100, 0, d, lat, cub, cuo);
    check("stall_out", d, 500);
    check("stall_lat", lat, 263);

    fill(~act, 16'sd0);
    bank[~act][0] = 16'sh2000;
    accept(16'sd1000);
    wait_out(0, 50, d, lat, cub, cuo);
    check("swap_old_bank", d, 500);
    check("swap_busy_cu", cub, 0);
    check("swap_cu_idle", cuo, 1);
    @(negedge clk);
    check("swap_cu_once", coeff_up, 0);
    accept(16'sd2000);
    wait_out(0, 0, d, lat, cub, cuo);
    check("swap_new_bank", d, 500);
    check("swap_no_repeat", cub, 0);

    accept(16'sd1000);
    repeat (30) @(negedge clk);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    repeat (10) @(negedge clk);
    do_reset();
    cub = 0;
    for (int i = 0; i < 10; i++) begin
      cub += int'(coeff_up) + int'(out_valid);
      @(negedge clk);
    end
    check("midrst_quiet", cub, 0);
    accept(16'sd1000);
    wait_out(0, 0, d, lat, cub, cuo);
    check("midrst_out", d, 250);
    check("midrst_lat", lat, 258);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
